// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator and pixel output stage.
// A free-running column/line counter pair is decoded into timing flags.
// The flags are delayed LOOKAHEAD enabled ticks so the coordinates lead the
// pixel by enough ticks to cover the renderer's pipeline latency.
// Every register advances only on PixelEnable, so the block can run from a
// fast clock with a divided strobe.
module vga_sync_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int COLOR_W   = 8,
  parameter int LOOKAHEAD = 1,
  parameter int CW        = 10
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 PixelEnable,
  input  logic [3*COLOR_W-1:0] RGB,
  output logic [CW-1:0]        ColunaOut,
  output logic [CW-1:0]        LinhaOut,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 blank,
  output logic [COLOR_W-1:0]   R,
  output logic [COLOR_W-1:0]   G,
  output logic [COLOR_W-1:0]   B,
  output logic                 FrameStart,
  output logic                 LineStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  // Asserted levels of the sync pins.
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // One pipeline stage of timing. Sync fields hold pin levels, with polarity
  // already applied, so the final stage drives the pins directly.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
  } tflags_t;

  localparam tflags_t IDLE = '{act: 1'b0, hs: ~HS_ON, vs: ~VS_ON,
                               fs: 1'b0, ls: 1'b0};

  logic [CW-1:0]        h_cnt, v_cnt;
  tflags_t              dec;
  tflags_t              pipe [LOOKAHEAD];
  logic                 tap_act;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 pe_d;

  // Column/line counters: column wraps at H_TOTAL-1 and carries into the line.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (PixelEnable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Decode the current counter pair into the flags for that pixel.
  always_comb begin
    dec     = IDLE;
    dec.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    dec.hs  = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_ON : ~HS_ON;
    dec.vs  = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_ON : ~VS_ON;
    dec.fs  = (h_cnt == '0) && (v_cnt == '0);
    dec.ls  = (h_cnt == '0);
  end

  // LOOKAHEAD-deep flag delay; the last stage is the output register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < LOOKAHEAD; i++) pipe[i] <= IDLE;
    end else if (PixelEnable) begin
      pipe[0] <= dec;
      for (int i = 1; i < LOOKAHEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Visibility of the stage about to enter the output register. It gates
  // the colour sampled on the same edge.
  generate
    if (LOOKAHEAD == 1) begin : g_tap_dec
      assign tap_act = dec.act;
    end else begin : g_tap_pipe
      assign tap_act = pipe[LOOKAHEAD-2].act;
    end
  endgenerate

  // Colour register: renderer data for visible pixels, black in porches/sync.
  always_ff @(posedge Clock) begin
    if (Reset)            rgb_q <= '0;
    else if (PixelEnable) rgb_q <= tap_act ? RGB : '0;
  end

  // Remembers whether the last edge was an enabled tick. This keeps the
  // start pulses one clock wide when PixelEnable is a strobe.
  always_ff @(posedge Clock) begin
    if (Reset) pe_d <= 1'b0;
    else       pe_d <= PixelEnable;
  end

  assign ColunaOut  = h_cnt;
  assign LinhaOut   = v_cnt;
  assign h_sync     = pipe[LOOKAHEAD-1].hs;
  assign v_sync     = pipe[LOOKAHEAD-1].vs;
  assign blank      = pipe[LOOKAHEAD-1].act;
  assign FrameStart = pipe[LOOKAHEAD-1].fs & pe_d;
  assign LineStart  = pipe[LOOKAHEAD-1].ls & pe_d;
  assign R          = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign G          = rgb_q[2*COLOR_W-1:COLOR_W];
  assign B          = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with small timing (H 8/2/3/3, V 4/1/2/1).
// Instance A: LOOKAHEAD=1, active-low syncs, combinational renderer.
// Instance B: LOOKAHEAD=2, active-high syncs, one-register renderer.
module tb_vga_sync_gen;
  localparam int CW = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic PixelEnable = 1'b1;
  always #5 Clock = ~Clock;

  logic [23:0]   rgb_a, rgb_b;
  logic [CW-1:0] col_a, lin_a, col_b, lin_b;
  logic          hs_a, vs_a, bl_a, fs_a, ls_a;
  logic          hs_b, vs_b, bl_b, fs_b, ls_b;
  logic [7:0]    r_a, g_a, b_a, r_b, g_b, b_b;

  // Test pattern: R=x, G=y, B=x^A5.
  function automatic logic [23:0] pat(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return {3'b000, x, 3'b000, y, 8'hA5 ^ {3'b000, x}};
  endfunction

  assign rgb_a = pat(col_a, lin_a);
  always @(posedge Clock) begin
    if (Reset)            rgb_b <= '0;
    else if (PixelEnable) rgb_b <= pat(col_b, lin_b);
  end

  vga_sync_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                 .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                 .HS_POL(0), .VS_POL(0), .COLOR_W(8), .LOOKAHEAD(1), .CW(CW))
  dut_a (.Clock(Clock), .Reset(Reset), .PixelEnable(PixelEnable), .RGB(rgb_a),
         .ColunaOut(col_a), .LinhaOut(lin_a), .h_sync(hs_a), .v_sync(vs_a),
         .blank(bl_a), .R(r_a), .G(g_a), .B(b_a), .FrameStart(fs_a), .LineStart(ls_a));

  vga_sync_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                 .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                 .HS_POL(1), .VS_POL(1), .COLOR_W(8), .LOOKAHEAD(2), .CW(CW))
  dut_b (.Clock(Clock), .Reset(Reset), .PixelEnable(PixelEnable), .RGB(rgb_b),
         .ColunaOut(col_b), .LinhaOut(lin_b), .h_sync(hs_b), .v_sync(vs_b),
         .blank(bl_b), .R(r_b), .G(g_b), .B(b_b), .FrameStart(fs_b), .LineStart(ls_b));

  typedef struct packed {
    logic        act, hs, vs, fs, ls;
    logic [23:0] rgb;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n = 0;            // enabled ticks since reset release
  bit   last_en = 1'b0;
  exp_t qa[$], qb[$];
  exp_t cur_a, cur_b;

  function automatic exp_t idle(input logic pol);
    exp_t e;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    return e;
  endfunction

  // Expected output fields for the pixel at enabled tick m.
  function automatic exp_t expect_at(input int m, input logic pol);
    exp_t e;
    int x, y;
    x = m % 16;
    y = (m / 16) % 8;
    e.act = (x < 8) && (y < 4);
    e.hs  = (x >= 10 && x < 13) ? pol : ~pol;
    e.vs  = (y >= 5 && y < 7) ? pol : ~pol;
    e.fs  = (x == 0) && (y == 0);
    e.ls  = (x == 0);
    e.rgb = e.act ? pat(CW'(x), CW'(y)) : 24'h0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s tick=%0d got=%h expected=%h", nm, n, got, exp);
    end
  endtask

  // One clock: update the scoreboard for the edge just taken, then compare.
  task automatic step();
    logic pe, rs;
    pe = PixelEnable;
    rs = Reset;
    @(posedge Clock);
    #1;
    if (rs) begin
      n = 0;
      qa.delete();
      qb.delete();
      cur_a = idle(1'b0);
      cur_b = idle(1'b1);
      last_en = 1'b0;
    end else if (pe) begin
      qa.push_back(expect_at(n, 1'b0));
      qb.push_back(expect_at(n, 1'b1));
      n++;
      cur_a = qa.pop_front();
      if (qb.size() > 1) cur_b = qb.pop_front();
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    chk("cycle_a", 64'({col_a, lin_a, hs_a, vs_a, bl_a, fs_a, ls_a, r_a, g_a, b_a}),
        64'({CW'(n % 16), CW'((n / 16) % 8), cur_a.hs, cur_a.vs, cur_a.act,
             cur_a.fs & last_en, cur_a.ls & last_en, cur_a.rgb}));
    chk("cycle_b", 64'({col_b, lin_b, hs_b, vs_b, bl_b, fs_b, ls_b, r_b, g_b, b_b}),
        64'({CW'(n % 16), CW'((n / 16) % 8), cur_b.hs, cur_b.vs, cur_b.act,
             cur_b.fs & last_en, cur_b.ls & last_en, cur_b.rgb}));
  endtask

  // Hand-derived checkpoints: A ctl = {hs,vs,blank,fs,ls}, B ctl = {hs,vs,blank,fs}.
  typedef struct {
    int         tick;
    logic [4:0] ah;
    logic [4:0] av;
    logic [4:0] actl;
    logic [3:0] bctl;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, fa1, fa2, fb1, c0, first_fs, second_fs, ls1, ls2, wide;
    logic prev_fs;

    tbl.push_back('{0,   5'd0,  5'd0, 5'b11000, 4'b0000});
    tbl.push_back('{1,   5'd1,  5'd0, 5'b11111, 4'b0000});
    tbl.push_back('{2,   5'd2,  5'd0, 5'b11100, 4'b0011});
    tbl.push_back('{3,   5'd3,  5'd0, 5'b11100, 4'b0010});
    tbl.push_back('{9,   5'd9,  5'd0, 5'b11000, 4'b0010});
    tbl.push_back('{10,  5'd10, 5'd0, 5'b11000, 4'b0000});
    tbl.push_back('{11,  5'd11, 5'd0, 5'b01000, 4'b0000});
    tbl.push_back('{12,  5'd12, 5'd0, 5'b01000, 4'b1000});
    tbl.push_back('{14,  5'd14, 5'd0, 5'b11000, 4'b1000});
    tbl.push_back('{15,  5'd15, 5'd0, 5'b11000, 4'b0000});
    tbl.push_back('{17,  5'd1,  5'd1, 5'b11101, 4'b0000});
    tbl.push_back('{18,  5'd2,  5'd1, 5'b11100, 4'b0010});
    tbl.push_back('{65,  5'd1,  5'd4, 5'b11001, 4'b0000});
    tbl.push_back('{81,  5'd1,  5'd5, 5'b10001, 4'b0000});
    tbl.push_back('{82,  5'd2,  5'd5, 5'b10000, 4'b0100});
    tbl.push_back('{97,  5'd1,  5'd6, 5'b10001, 4'b0100});
    tbl.push_back('{113, 5'd1,  5'd7, 5'b11001, 4'b0100});
    tbl.push_back('{128, 5'd0,  5'd0, 5'b11000, 4'b0000});
    tbl.push_back('{129, 5'd1,  5'd0, 5'b11111, 4'b0000});
    tbl.push_back('{130, 5'd2,  5'd0, 5'b11100, 4'b0011});

    cur_a = idle(1'b0);
    cur_b = idle(1'b1);

    // Reset with PixelEnable high: outputs must sit in the idle state.
    Reset = 1'b1;
    PixelEnable = 1'b1;
    repeat (3) step();
    Reset = 1'b0;

    // Table-driven checkpoints over the first frame and into the second.
    for (int i = 0; i < tbl.size(); i++) begin
      guard = 0;
      while (n < tbl[i].tick && guard < 400) begin
        step();
        guard++;
      end
      chk($sformatf("vec%0d_a", tbl[i].tick), 64'({col_a, lin_a, hs_a, vs_a, bl_a, fs_a, ls_a}),
          64'({tbl[i].ah, tbl[i].av, tbl[i].actl}));
      chk($sformatf("vec%0d_b", tbl[i].tick), 64'({hs_b, vs_b, bl_b, fs_b}), 64'(tbl[i].bctl));
    end

    // Finish a full second frame under per-pixel scoreboard comparison.
    guard = 0;
    while (n < 260 && guard < 400) begin
      step();
      guard++;
    end

    // Mid-frame reset at line 2, column 5.
    guard = 0;
    while ((n % 128) != 37 && guard < 200) begin
      step();
      guard++;
    end
    chk("pre_reset_pos", 64'({col_a, lin_a}), 64'({5'd5, 5'd2}));
    Reset = 1'b1;
    step();
    chk("reset_outputs", 64'({bl_a, hs_a, vs_a, r_a, g_a, b_a, fs_a, ls_a,
                              bl_b, hs_b, vs_b, r_b, g_b, b_b}),
        64'({1'b0, 1'b1, 1'b1, 24'h0, 2'b00, 1'b0, 1'b0, 1'b0, 24'h0}));
    chk("reset_counters", 64'({col_a, lin_a, col_b, lin_b}), 64'(0));
    step();
    step();
    Reset = 1'b0;

    // Restart: first FrameStart after 1 (A) / 2 (B) ticks, next one 128 later.
    fa1 = -1;
    fa2 = -1;
    fb1 = -1;
    for (int c = 1; c <= 140; c++) begin
      step();
      if (fs_a) begin
        if (fa1 < 0) fa1 = c;
        else if (fa2 < 0) fa2 = c;
      end
      if (fs_b && fb1 < 0) fb1 = c;
    end
    chk("restart_fs_a", 64'(fa1), 64'(1));
    chk("restart_fs_b", 64'(fb1), 64'(2));
    chk("frame_period", 64'(fa2 - fa1), 64'(128));

    // PixelEnable toggling every clock: periods double, pulses stay 1 clock.
    first_fs = -1;
    second_fs = -1;
    ls1 = -1;
    ls2 = -1;
    wide = 0;
    prev_fs = 1'b0;
    c0 = 0;
    for (int c = 0; c < 700; c++) begin
      PixelEnable = ~PixelEnable;
      step();
      if (fs_a) begin
        if (prev_fs) wide++;
        if (first_fs < 0) first_fs = c;
        else if (second_fs < 0) second_fs = c;
      end
      prev_fs = fs_a;
      if (ls_a) begin
        if (ls1 < 0) ls1 = c;
        else if (ls2 < 0) ls2 = c;
      end
      c0++;
    end
    chk("half_rate_frame_period", 64'(second_fs - first_fs), 64'(256));
    chk("half_rate_line_period", 64'(ls2 - ls1), 64'(32));
    chk("half_rate_fs_width", 64'(wide), 64'(0));
    chk("half_rate_cycles", 64'(c0), 64'(700));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
